// File: rtl/msk_and_hpc3_sched_if.sv
// Bundle of requester, response, PRNG and gadget signals around the masked-AND scheduler.
interface msk_and_hpc3_sched_if #(
  parameter int unsigned D = 2
);
  localparam int unsigned RND = D * (D - 1);

  logic           req0_valid;
  logic           req0_ready;
  logic [D-1:0]   req0_a;
  logic [D-1:0]   req0_b;
  logic           req1_valid;
  logic           req1_ready;
  logic [D-1:0]   req1_a;
  logic [D-1:0]   req1_b;
  logic           rsp0_valid;
  logic           rsp0_ready;
  logic           rsp1_valid;
  logic           rsp1_ready;
  logic [D-1:0]   rsp_data;
  logic           rnd_valid;
  logic           rnd_ready;
  logic [RND-1:0] rnd_in;
  logic [D-1:0]   g_ina;
  logic [D-1:0]   g_inb;
  logic [D-1:0]   g_inb_prev;
  logic [RND-1:0] g_rnd;
  logic [D-1:0]   g_out;

  // Environment side: requesters, PRNG and the gadget itself.
  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    output rnd_valid, rnd_in,
    output g_out,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data,
    input  rnd_ready,
    input  g_ina, g_inb, g_inb_prev, g_rnd
  );

  // Scheduler side.
  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    input  rnd_valid, rnd_in,
    input  g_out,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data,
    output rnd_ready,
    output g_ina, g_inb, g_inb_prev, g_rnd
  );
endinterface

// File: rtl/msk_and_hpc3_sched.sv
// Time-shares one d-share HPC3 masked AND gadget between two requesters.
// Round-robin arbitration, b-preload before execute, PRNG gated to the execute
// cycle, and a result buffer held until the owning requester takes it.
module msk_and_hpc3_sched #(
  parameter int unsigned D = 2
) (
  input logic                 clk,
  input logic                 rst,
  msk_and_hpc3_sched_if.slave bus
);
  localparam int unsigned RND = D * (D - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_CAPT = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [D-1:0]   a_q;
  logic [D-1:0]   b_q;
  logic [D-1:0]   inb_prev_q;
  logic [D-1:0]   rsp_data_q;
  // Owner of the current/last operation; doubles as the round-robin pointer.
  logic           owner_q;
  logic           rsp0_valid_q;
  logic           rsp1_valid_q;

  logic           grant0;
  logic           grant1;
  logic           rsp_hs;
  logic           req0_ready_c;
  logic           req1_ready_c;
  logic           rnd_ready_c;
  logic [D-1:0]   g_ina_c;
  logic [D-1:0]   g_inb_c;
  logic [RND-1:0] g_rnd_c;

  // On contention favour the requester not served last.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | owner_q);
  assign grant1 = bus.req1_valid & ~grant0;
  assign rsp_hs = (rsp0_valid_q & bus.rsp0_ready) | (rsp1_valid_q & bus.rsp1_ready);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and gadget/handshake drive; everything idles while rst is high.
  always_comb begin
    state_d      = state_q;
    req0_ready_c = 1'b0;
    req1_ready_c = 1'b0;
    rnd_ready_c  = 1'b0;
    g_ina_c      = '0;
    g_inb_c      = '0;
    g_rnd_c      = '0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          req0_ready_c = grant0;
          req1_ready_c = grant1;
          if (grant0 | grant1) begin
            state_d = S_PRE;
          end
        end
        S_PRE: begin
          g_inb_c = b_q;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          // b stays on the port so g_inb_prev matches g_inb when we execute.
          g_inb_c = b_q;
          if (bus.rnd_valid) begin
            g_ina_c     = a_q;
            g_rnd_c     = bus.rnd_in;
            rnd_ready_c = 1'b1;
            state_d     = S_CAPT;
          end
        end
        S_CAPT: begin
          state_d = S_RESP;
        end
        S_RESP: begin
          if (rsp_hs) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Operand capture, b history and the response buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      owner_q      <= 1'b1;
      inb_prev_q   <= '0;
      rsp_data_q   <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      inb_prev_q <= g_inb_c;
      if (req0_ready_c | req1_ready_c) begin
        a_q     <= req1_ready_c ? bus.req1_a : bus.req0_a;
        b_q     <= req1_ready_c ? bus.req1_b : bus.req0_b;
        owner_q <= req1_ready_c;
      end
      if (state_q == S_CAPT) begin
        rsp_data_q   <= bus.g_out;
        rsp0_valid_q <= ~owner_q;
        rsp1_valid_q <= owner_q;
      end else if ((state_q == S_RESP) && rsp_hs) begin
        rsp_data_q   <= '0;
        rsp0_valid_q <= 1'b0;
        rsp1_valid_q <= 1'b0;
      end
    end
  end

  // Port drive.
  assign bus.req0_ready = req0_ready_c;
  assign bus.req1_ready = req1_ready_c;
  assign bus.rnd_ready  = rnd_ready_c;
  assign bus.g_ina      = g_ina_c;
  assign bus.g_inb      = g_inb_c;
  assign bus.g_rnd      = g_rnd_c;
  assign bus.g_inb_prev = inb_prev_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;

endmodule
